serial_bit_source: RTL and testbench
====================================

Name: serial_bit_source

Overview:
- Parallel-to-serial stimulus stage that sits directly upstream of the sequence detector and drives its single-bit input `x`.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock.
- Flags each valid bit and pulses at the end of each word.
- Optional idle gap between words.

Parameters:
- WIDTH, 8, bits per word (minimum 2).
- GAP, 0, idle cycles with x=0 inserted after each word (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the sequence detector.
- x_valid  output  1  x carries a word bit this cycle.
- busy  output  1  word in flight (SHIFT, PAR or GAP state).
- word_done  output  1  one-cycle pulse coincident with the final bit of a word.

Behaviour:
- Reset: rst=1 at a rising edge forces the state to IDLE, x=0, x_valid=0, busy=0, word_done=0. The shift register and counter are cleared.
- Reset mid-word: the word is dropped and no word_done is produced. din_ready=1 from the first cycle after reset.
- All outputs except din_ready are registered. din_ready is combinational from state and counter only, never from din_valid.
- States:
  - IDLE: din_ready=1, x=0, x_valid=0. On din_valid&&din_ready, latch din into the shift register, set cnt=WIDTH-1 and go to SHIFT.
  - SHIFT: x=shreg[WIDTH-1] and x_valid=1. Each cycle, shift left by one (zero fill) and decrement cnt. At cnt==0 this is the final bit unless PAR follows.
  - PAR: present only with the optional feature. One cycle, x=parity, x_valid=1.
  - GAP: GAP cycles with x=0 and x_valid=0, then go to IDLE.
- Latency:
  - The first bit appears on x in the cycle after the accepting edge.
  - The word occupies WIDTH cycles (WIDTH+1 with parity).
- Final bit cycle:
  - word_done=1.
  - Next state is GAP if GAP>0, otherwise IDLE.
- Back-to-back, GAP==0 only: din_ready is also 1 during the final bit cycle. An accept there loads the next word, and its MSB follows on x the next cycle with no bubble. x_valid stays 1 continuously.
- With GAP>0, din_ready=0 throughout SHIFT, PAR and GAP.
- din and din_valid are ignored whenever din_ready=0. The upstream side holds din stable only until the accepting edge.
- Counter: width $clog2(WIDTH). It must not wrap; it reloads only on accept.
- GAP counter: 4 bits, loaded with GAP-1 on entry to GAP.

Optional Feature:
- Macro: SERIAL_BIT_SOURCE_PARITY_EN.
- Defined:
  - The parity register accumulates the XOR of the bits shifted out.
  - After the last data bit, the PAR state emits the even-parity bit (XOR of all WIDTH data bits). x_valid=1 in PAR.
  - word_done moves to the PAR cycle.
  - The back-to-back din_ready window moves to the PAR cycle.
- Undefined: no PAR state, no parity register; behaviour is exactly as above.

Decomposition:
- Package serial_bit_source_pkg holds:
  - typedef enum logic [1:0] state_t with values IDLE=2'b00, SHIFT=2'b01, PAR=2'b10, GAP=2'b11.
  - localparam GAP_CNT_W=4.
- No sub-module is required. If the counters are factored out, the single natural sub-module is sbs_down_counter: load, decrement, zero flag.

Test Plan:
- Reset and idle: hold rst=1 for 2 cycles with din_valid=1 -> x=0, x_valid=0, busy=0, word_done=0. Then rst=0 -> din_ready=1 immediately.
- Single word (WIDTH=8, GAP=0): din=8'b1011_0110 accepted at edge N -> x=1,0,1,1,0,1,1,0 on cycles N+1..N+8, x_valid=1 for those 8 cycles, word_done only on N+8. x=0 and x_valid=0 at N+9 if no new word.
- Back-to-back (GAP=0): din_valid held high with 8'hB6 then 8'h0F -> 16 consecutive x_valid cycles; bit 9 = 0 (MSB of 8'h0F); word_done on cycles 8 and 16.
- Gap (GAP=2): two words 8'hFF -> 8 ones, then 2 cycles x=0 with x_valid=0 and din_ready=0, then IDLE for 1 cycle, then the second word.
- Reset mid-word: rst=1 on the 4th bit of 8'hB6 -> next cycle x=0, x_valid=0, busy=0, no word_done; the next accepted word starts cleanly from its MSB.
- Parity (SERIAL_BIT_SOURCE_PARITY_EN, WIDTH=4): din=4'b1101 -> x=1,1,0,1 then parity bit 1 in cycle 5. word_done on cycle 5 and not on cycle 4. Driving the sequence detector with this stream gives the detector response expected for 11011.

Source files
------------

// File: rtl/serial_bit_source_pkg.sv
// rtl/serial_bit_source_pkg.sv - shared state encoding and widths for serial_bit_source
package serial_bit_source_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10,
        GAP   = 2'b11
    } state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serial_bit_source.sv
// rtl/serial_bit_source.sv - MSB-first parallel-to-serial bit source, optional parity via SERIAL_BIT_SOURCE_PARITY_EN
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

    state_t                 state;
    logic [WIDTH-1:0]       shreg;
    logic [CNT_W-1:0]       cnt;
    logic [GAP_CNT_W-1:0]   gcnt;
    logic                   final_cycle;
    logic                   accept;

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    logic par;
    assign final_cycle = (state == PAR);
`else
    assign final_cycle = (state == SHIFT) && (cnt == '0);
`endif

    // Back-to-back acceptance in the final bit cycle is only legal without a gap
    assign din_ready = (state == IDLE) || ((GAP == 0) && final_cycle);
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            x         <= 1'b0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (accept) begin
                // x is registered, so the MSB is presented straight from din
                state   <= SHIFT;
                shreg   <= {din[WIDTH-2:0], 1'b0};
                cnt     <= CNT_LOAD;
                x       <= din[WIDTH-1];
                x_valid <= 1'b1;
                busy    <= 1'b1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                par     <= din[WIDTH-1];
`endif
            end else if (final_cycle) begin
                x       <= 1'b0;
                x_valid <= 1'b0;
                if (GAP > 0) begin
                    state <= serial_bit_source_pkg::GAP;
                    gcnt  <= GAP_LOAD;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                    end
                    SHIFT: begin
                        if (cnt != '0) begin
                            x     <= shreg[WIDTH-1];
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            cnt   <= cnt - 1'b1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                            par   <= par ^ shreg[WIDTH-1];
`else
                            word_done <= (cnt == CNT_W'(1));
`endif
                        end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
                        else begin
                            state     <= PAR;
                            x         <= par;
                            word_done <= 1'b1;
                        end
`endif
                    end
                    PAR: begin
                        state <= IDLE;
                    end
                    serial_bit_source_pkg::GAP: begin
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        if (gcnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gcnt <= gcnt - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// tb/tb_serial_bit_source.sv - scoreboard bench for serial_bit_source with GAP=0 and GAP=2 instances
module tb_serial_bit_source;

    localparam int W  = 8;
    localparam int G0 = 0;
    localparam int G1 = 2;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic b;
        logic d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         din_valid;
    logic [W-1:0] din;
    logic [1:0]   din_ready, x, x_valid, busy, word_done;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   left[2];
    logic er[2];
    logic acc[2];
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .GAP(G0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[0]), .x(x[0]), .x_valid(x_valid[0]),
        .busy(busy[0]), .word_done(word_done[0])
    );

    serial_bit_source #(.WIDTH(W), .GAP(G1)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[1]), .x(x[1]), .x_valid(x_valid[1]),
        .busy(busy[1]), .word_done(word_done[1])
    );

    function automatic int gap_of(int i);
        return (i == 0) ? G0 : G1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is its W bits MSB-first, then the even-parity bit if enabled
    function automatic void push_word(int i, logic [W-1:0] w);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.b = w[W-1-k];
            e.d = (k == W-1) && (P == 0);
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (P != 0) begin
            e.b = ^w;
            e.d = 1'b1;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (x_valid[i] === 1'b1) begin
                    exp_t e;
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        check($sformatf("dut%0d unexpected bit", i), 1, 0);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dut%0d x", i), 32'(x[i]), 32'(e.b));
                        check($sformatf("dut%0d word_done", i), 32'(word_done[i]), 32'(e.d));
                    end
                end
            end
        end
    end

    // One clock of stimulus; the occupancy model predicts handshake and idle outputs
    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            er[i] = (left[i] == 0) || (gap_of(i) == 0 && left[i] == 1);
            check($sformatf("dut%0d din_ready", i), 32'(din_ready[i]), 32'(er[i]));
            check($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(left[i] > 0));
            check($sformatf("dut%0d x_valid", i), 32'(x_valid[i]), 32'(left[i] > gap_of(i)));
            if (left[i] <= gap_of(i)) begin
                check($sformatf("dut%0d idle x", i), 32'(x[i]), 0);
                check($sformatf("dut%0d idle word_done", i), 32'(word_done[i]), 0);
            end
        end
        rst       = r;
        din_valid = v;
        din       = d;
        for (int i = 0; i < 2; i++) begin
            acc[i] = !r && v && er[i];
            if (acc[i]) push_word(i, d);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                left[i] = 0;
                if (i == 0) q0.delete(); else q1.delete();
            end else if (acc[i]) begin
                left[i] = W + P + gap_of(i);
            end else if (left[i] > 0) begin
                left[i]--;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'hB6;
        left[0]   = 0;
        left[1]   = 0;
        @(posedge clk);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 8'hB6);

        step(1'b0, 1'b1, 8'hB6);
        repeat (12) step(1'b0, 1'b0, W'($urandom));

        step(1'b0, 1'b1, 8'hB6);
        repeat (20) step(1'b0, 1'b1, 8'h0F);
        repeat (14) step(1'b0, 1'b0, 8'h00);

        repeat (14) step(1'b0, 1'b1, 8'hFF);
        repeat (14) step(1'b0, 1'b0, 8'h00);

        step(1'b0, 1'b1, 8'hB6);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h5A);
        repeat (14) step(1'b0, 1'b0, 8'h00);

        repeat (600) step(($urandom % 60) == 0, ($urandom % 3) != 0, W'($urandom));

        repeat (20) step(1'b0, 1'b0, 8'h00);
        check("dut0 leftover bits", q0.size(), 0);
        check("dut1 leftover bits", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
